hvac_sequencer: RTL and testbench
=================================

Name: hvac_sequencer

Overview:
Controller that sequences the heater and cooler actuators from a sampled 5-bit temperature. It uses hysteresis thresholds, enforces a minimum run time per actuation and a lockout period after every actuation, and guarantees that heating and cooling are never active together. It sits between the temperature sensor interface and the actuator drive outputs at the top level of the thermostat design.

Parameters:
HEAT_ON, 5'd18, heating requested when temp_q <= HEAT_ON
HEAT_OFF, 5'd20, heating may stop when temp_q >= HEAT_OFF
COOL_ON, 5'd22, cooling requested when temp_q >= COOL_ON
COOL_OFF, 5'd20, cooling may stop when temp_q <= COOL_OFF
MIN_RUN, 8, minimum consecutive cycles heating or cooling stays high (1..255)
MIN_OFF, 4, lockout cycles after any actuation ends (1..255)

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst  input  1  synchronous, active-high reset
enable  input  1  master enable; 0 forces actuators off
temp_valid  input  1  strobe: temperature is valid this cycle
temperature  input  5  unsigned temperature sample
heating  output  1  registered heater drive
cooling  output  1  registered cooler drive
state  output  2  debug state code: IDLE=00, HEAT=01, COOL=10, LOCKOUT=11

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; run_cnt=0, off_cnt=0, temp_q=0, have_sample=0.
  - heating=0 and cooling=0 from the next edge.
  - A reset mid-operation aborts immediately. There is no lockout after a reset.
- Sampling:
  - On an edge with temp_valid=1, temp_q<=temperature and have_sample<=1. Otherwise temp_q holds.
  - All comparisons are unsigned 5-bit against temp_q.
- Outputs are Moore: heating=(state==HEAT) and cooling=(state==COOL), both registered. The two are never 1 simultaneously.
- Latency: a temperature presented with temp_valid at edge n can change state, and therefore the outputs, at edge n+1 at the earliest.
- IDLE:
  - If have_sample=0 or enable=0, stay in IDLE.
  - Else if temp_q<=HEAT_ON, go to HEAT.
  - Else if temp_q>=COOL_ON, go to COOL.
  - Else stay in IDLE.
  - HEAT has priority if both conditions are true, which is only possible with misconfigured parameters.
- HEAT:
  - run_cnt is cleared on entry and increments each cycle in HEAT, saturating at MIN_RUN-1.
  - Go to LOCKOUT when enable=0; this safety override bypasses MIN_RUN.
  - Also go to LOCKOUT when run_cnt==MIN_RUN-1 and temp_q>=HEAT_OFF.
  - Consequence: with enable held at 1, heating stays high for at least MIN_RUN cycles, and exactly MIN_RUN cycles if the off condition is already true.
- COOL: identical to HEAT, using temp_q<=COOL_OFF as the off condition.
- LOCKOUT:
  - off_cnt is cleared on entry and increments each cycle.
  - Go to IDLE when off_cnt==MIN_OFF-1, so LOCKOUT lasts exactly MIN_OFF cycles.
  - Lockout ignores enable and temperature and always completes.
- Mode-change gap: any heat-to-cool or cool-to-heat transition passes through LOCKOUT then IDLE. The minimum gap with both outputs 0 is MIN_OFF+1 cycles.
- Counters are 8 bits wide and never wrap: they saturate or are cleared on state entry.
- A temp_valid arriving during LOCKOUT still updates temp_q. IDLE acts on the latest sample.
- Parameter legality: HEAT_ON < HEAT_OFF <= COOL_OFF < COOL_ON, MIN_RUN>=1, MIN_OFF>=1. Behaviour outside these ranges is unspecified.

Test Plan:
- Reset with temperature=5 and temp_valid=0: heating=cooling=0 and state=00 for 10 cycles. After one temp_valid with 5, heating=1 at the next edge.
- Heat cycle: temp 15 valid, then 21 valid on the cycle heating rises. Heating is high for exactly 8 cycles, then state=11 for 4 cycles, then IDLE. Temp held at 21 gives no further action.
- Cool cycle with hysteresis: temp 22 gives cooling=1. Temp 21 after 10 cycles leaves cooling high. Temp 20 gives cooling=0 on the next edge, then LOCKOUT for 4 cycles.
- Mode change: heating active with temp held at 15, then temp 25 and hold. Heating stays high until 8 cycles have elapsed, then exactly 5 cycles with both outputs 0, then cooling=1. Heating and cooling are never 1 together.
- Enable override: while heating at cycle 3 of the run, drop enable. Heating=0 at the next edge, LOCKOUT runs the full 4 cycles, and IDLE persists while enable=0 even at temp 10.
- Reset mid-run: assert rst during COOL. Cooling=0 and state=00 at the next edge, have_sample=0, and no action until a new temp_valid.

Source files
------------

// File: rtl/hvac_sequencer.sv
// ---------------------------------------------------------------------------
// hvac_sequencer
//
// Purpose:
//   Drives the heater and cooler actuators from a sampled 5-bit temperature.
//
//   - Switching uses hysteresis thresholds.
//   - Every actuation runs for at least MIN_RUN cycles. Dropping enable is a
//     safety override and may cut a run short.
//   - Every actuation is followed by a lockout of exactly MIN_OFF cycles.
//   - Heating and cooling are never driven together. A change of mode always
//     passes through LOCKOUT and then IDLE.
//
// Ports:
//   clk          in   1  system clock, rising edge
//   rst          in   1  synchronous, active-high reset
//   enable       in   1  master enable; 0 forces the actuators off
//   temp_valid   in   1  strobe: temperature is valid this cycle
//   temperature  in   5  unsigned temperature sample
//   heating      out  1  registered heater drive
//   cooling      out  1  registered cooler drive
//   state        out  2  debug state code: IDLE=00 HEAT=01 COOL=10 LOCKOUT=11
// ---------------------------------------------------------------------------
module hvac_sequencer #(
  parameter logic [4:0] HEAT_ON  = 5'd18,
  parameter logic [4:0] HEAT_OFF = 5'd20,
  parameter logic [4:0] COOL_ON  = 5'd22,
  parameter logic [4:0] COOL_OFF = 5'd20,
  parameter int         MIN_RUN  = 8,
  parameter int         MIN_OFF  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       temp_valid,
  input  logic [4:0] temperature,
  output logic       heating,
  output logic       cooling,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    HEAT    = 2'b01,
    COOL    = 2'b10,
    LOCKOUT = 2'b11
  } state_e;

  // Terminal counter values. A run ends no earlier than RUN_LAST, and the
  // lockout ends exactly at OFF_LAST.
  localparam logic [7:0] RUN_LAST = 8'(MIN_RUN - 1);
  localparam logic [7:0] OFF_LAST = 8'(MIN_OFF - 1);

  state_e     state_q, state_d;
  logic [7:0] run_cnt_q, run_cnt_d;
  logic [7:0] off_cnt_q, off_cnt_d;
  logic [4:0] temp_q, temp_d;
  logic       have_sample_q, have_sample_d;
  logic       heating_q, heating_d;
  logic       cooling_q, cooling_d;

  // Sample capture.
  // The latest valid temperature is held until the next strobe. This includes
  // strobes that arrive during LOCKOUT, so IDLE always acts on fresh data.
  // have_sample blocks any action between reset and the first real sample.
  always_comb begin
    temp_d        = temp_q;
    have_sample_d = have_sample_q;
    if (temp_valid) begin
      temp_d        = temperature;
      have_sample_d = 1'b1;
    end
  end

  // Sequencer next-state logic.
  //
  // Counters are cleared on the transition into the state that uses them, so
  // the first cycle spent in HEAT, COOL or LOCKOUT always sees a count of 0.
  //
  // The run counter saturates at RUN_LAST. While the off condition is false,
  // the actuator simply stays on with the counter parked at its terminal
  // value. The off condition is only honoured once that value is reached.
  //
  // LOCKOUT ignores enable and temperature. Every actuation therefore ends
  // with a full MIN_OFF rest period.
  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    off_cnt_d = off_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (have_sample_q && enable) begin
          if (temp_q <= HEAT_ON) begin
            state_d   = HEAT;
            run_cnt_d = 8'd0;
          end else if (temp_q >= COOL_ON) begin
            state_d   = COOL;
            run_cnt_d = 8'd0;
          end
        end
      end

      HEAT: begin
        if (!enable || ((run_cnt_q == RUN_LAST) && (temp_q >= HEAT_OFF))) begin
          state_d   = LOCKOUT;
          off_cnt_d = 8'd0;
        end else if (run_cnt_q != RUN_LAST) begin
          run_cnt_d = run_cnt_q + 8'd1;
        end
      end

      COOL: begin
        if (!enable || ((run_cnt_q == RUN_LAST) && (temp_q <= COOL_OFF))) begin
          state_d   = LOCKOUT;
          off_cnt_d = 8'd0;
        end else if (run_cnt_q != RUN_LAST) begin
          run_cnt_d = run_cnt_q + 8'd1;
        end
      end

      LOCKOUT: begin
        if (off_cnt_q == OFF_LAST) begin
          state_d = IDLE;
        end else begin
          off_cnt_d = off_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Actuator drives.
  // The drives are decoded from the next state and then registered. As a
  // result, they toggle on the same edge as state_q and come straight from
  // flops. Only one of them can be true for any given state code.
  always_comb begin
    heating_d = (state_d == HEAT);
    cooling_d = (state_d == COOL);
  end

  // State register.
  // Reset aborts any activity immediately and skips the lockout. It also
  // discards the held sample, so the sequencer waits for a new strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      run_cnt_q     <= 8'd0;
      off_cnt_q     <= 8'd0;
      temp_q        <= 5'd0;
      have_sample_q <= 1'b0;
      heating_q     <= 1'b0;
      cooling_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_cnt_q     <= run_cnt_d;
      off_cnt_q     <= off_cnt_d;
      temp_q        <= temp_d;
      have_sample_q <= have_sample_d;
      heating_q     <= heating_d;
      cooling_q     <= cooling_d;
    end
  end

  assign heating = heating_q;
  assign cooling = cooling_q;
  assign state   = state_q;

endmodule

// File: tb/tb_hvac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_hvac_sequencer
//
// Purpose:
//   Self-checking bench for hvac_sequencer using the default parameters:
//   HEAT_ON=18, HEAT_OFF=20, COOL_ON=22, COOL_OFF=20, MIN_RUN=8, MIN_OFF=4.
//
//   Each scenario task first queues a cycle-by-cycle plan. Every plan entry
//   holds the inputs for one cycle and the outputs expected after that edge.
//   The task then drains the plan, driving each entry and comparing the
//   outputs against the expected values.
//
// Ports:
//   none (top-level bench)
// ---------------------------------------------------------------------------
module tb_hvac_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       temp_valid;
  logic [4:0] temperature;
  logic       heating;
  logic       cooling;
  logic [1:0] state;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_HEAT = 2'b01;
  localparam logic [1:0] S_COOL = 2'b10;
  localparam logic [1:0] S_LOCK = 2'b11;

  // One planned cycle.
  // The inputs are driven before the edge. exp holds the outputs expected
  // after that edge, packed as {heating, cooling, state}.
  typedef struct packed {
    logic       r;
    logic       en;
    logic       vld;
    logic [4:0] t;
    logic [3:0] exp;
  } step_t;

  step_t plan[$];

  hvac_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .temp_valid  (temp_valid),
    .temperature (temperature),
    .heating     (heating),
    .cooling     (cooling),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Advance to just past the next rising edge. Outputs are sampled here, and
  // the inputs for the following edge are driven here too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue n identical cycles together with the outputs they must produce.
  task automatic applyStimulus(input int n, input logic r, input logic en,
                               input logic vld, input logic [4:0] t,
                               input logic h, input logic c,
                               input logic [1:0] s);
    step_t st;
    st.r   = r;
    st.en  = en;
    st.vld = vld;
    st.t   = t;
    st.exp = {h, c, s};
    for (int i = 0; i < n; i++) plan.push_back(st);
  endtask

  task automatic doReset();
    rst         = 1'b1;
    enable      = 1'b1;
    temp_valid  = 1'b0;
    temperature = 5'd0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step_t      st;
    logic [3:0] got;
    int         idx = 0;
    rst         = 1'b1;
    enable      = 1'b1;
    temp_valid  = 1'b0;
    temperature = 5'd5;
    tick();
    compared++;
    if ({heating, cooling, state} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL reset_state: got %b expected 0000",
               {heating, cooling, state});
    end
    rst = 1'b0;
    applyStimulus(10, 0, 1, 0, 5'd5, 0, 0, S_IDLE);
    applyStimulus(1,  0, 1, 1, 5'd5, 0, 0, S_IDLE);
    applyStimulus(1,  0, 1, 0, 5'd5, 1, 0, S_HEAT);
    while (plan.size() > 0) begin
      st = plan.pop_front();
      rst = st.r; enable = st.en; temp_valid = st.vld; temperature = st.t;
      tick();
      got = {heating, cooling, state};
      compared++;
      if (got !== st.exp) begin
        mismatched++;
        $display("[TB] FAIL reset_wait step %0d: got hcs=%b expected hcs=%b",
                 idx, got, st.exp);
      end
      idx++;
    end
  endtask

  task automatic test_heat_cycle();
    step_t      st;
    logic [3:0] got;
    int         idx = 0;
    doReset();
    applyStimulus(1, 0, 1, 1, 5'd15, 0, 0, S_IDLE);
    applyStimulus(1, 0, 1, 0, 5'd15, 1, 0, S_HEAT);
    applyStimulus(1, 0, 1, 1, 5'd21, 1, 0, S_HEAT);
    applyStimulus(6, 0, 1, 0, 5'd21, 1, 0, S_HEAT);
    applyStimulus(4, 0, 1, 0, 5'd21, 0, 0, S_LOCK);
    applyStimulus(6, 0, 1, 0, 5'd21, 0, 0, S_IDLE);
    while (plan.size() > 0) begin
      st = plan.pop_front();
      rst = st.r; enable = st.en; temp_valid = st.vld; temperature = st.t;
      tick();
      got = {heating, cooling, state};
      compared++;
      if (got !== st.exp) begin
        mismatched++;
        $display("[TB] FAIL heat_cycle step %0d: got hcs=%b expected hcs=%b",
                 idx, got, st.exp);
      end
      idx++;
    end
  endtask

  task automatic test_cool_hysteresis();
    step_t      st;
    logic [3:0] got;
    int         idx = 0;
    doReset();
    applyStimulus(1,  0, 1, 1, 5'd22, 0, 0, S_IDLE);
    applyStimulus(10, 0, 1, 0, 5'd22, 0, 1, S_COOL);
    applyStimulus(1,  0, 1, 1, 5'd21, 0, 1, S_COOL);
    applyStimulus(3,  0, 1, 0, 5'd21, 0, 1, S_COOL);
    applyStimulus(1,  0, 1, 1, 5'd20, 0, 1, S_COOL);
    applyStimulus(4,  0, 1, 0, 5'd20, 0, 0, S_LOCK);
    applyStimulus(3,  0, 1, 0, 5'd20, 0, 0, S_IDLE);
    while (plan.size() > 0) begin
      st = plan.pop_front();
      rst = st.r; enable = st.en; temp_valid = st.vld; temperature = st.t;
      tick();
      got = {heating, cooling, state};
      compared++;
      if (got !== st.exp) begin
        mismatched++;
        $display("[TB] FAIL cool_hyst step %0d: got hcs=%b expected hcs=%b",
                 idx, got, st.exp);
      end
      idx++;
    end
  endtask

  task automatic test_mode_change();
    step_t      st;
    logic [3:0] got;
    int         idx = 0;
    doReset();
    applyStimulus(1, 0, 1, 1, 5'd15, 0, 0, S_IDLE);
    applyStimulus(3, 0, 1, 0, 5'd15, 1, 0, S_HEAT);
    applyStimulus(1, 0, 1, 1, 5'd25, 1, 0, S_HEAT);
    applyStimulus(4, 0, 1, 0, 5'd25, 1, 0, S_HEAT);
    applyStimulus(4, 0, 1, 0, 5'd25, 0, 0, S_LOCK);
    applyStimulus(1, 0, 1, 0, 5'd25, 0, 0, S_IDLE);
    applyStimulus(3, 0, 1, 0, 5'd25, 0, 1, S_COOL);
    while (plan.size() > 0) begin
      st = plan.pop_front();
      rst = st.r; enable = st.en; temp_valid = st.vld; temperature = st.t;
      tick();
      got = {heating, cooling, state};
      compared++;
      if (got !== st.exp) begin
        mismatched++;
        $display("[TB] FAIL mode_change step %0d: got hcs=%b expected hcs=%b",
                 idx, got, st.exp);
      end
      idx++;
    end
  endtask

  task automatic test_enable_override();
    step_t      st;
    logic [3:0] got;
    int         idx = 0;
    doReset();
    applyStimulus(1, 0, 1, 1, 5'd10, 0, 0, S_IDLE);
    applyStimulus(3, 0, 1, 0, 5'd10, 1, 0, S_HEAT);
    applyStimulus(4, 0, 0, 0, 5'd10, 0, 0, S_LOCK);
    applyStimulus(4, 0, 0, 0, 5'd10, 0, 0, S_IDLE);
    applyStimulus(1, 0, 0, 1, 5'd10, 0, 0, S_IDLE);
    applyStimulus(1, 0, 0, 0, 5'd10, 0, 0, S_IDLE);
    applyStimulus(1, 0, 1, 0, 5'd10, 1, 0, S_HEAT);
    while (plan.size() > 0) begin
      st = plan.pop_front();
      rst = st.r; enable = st.en; temp_valid = st.vld; temperature = st.t;
      tick();
      got = {heating, cooling, state};
      compared++;
      if (got !== st.exp) begin
        mismatched++;
        $display("[TB] FAIL enable_override step %0d: got hcs=%b expected hcs=%b",
                 idx, got, st.exp);
      end
      idx++;
    end
  endtask

  task automatic test_reset_mid_run();
    step_t      st;
    logic [3:0] got;
    int         idx = 0;
    doReset();
    applyStimulus(1, 0, 1, 1, 5'd25, 0, 0, S_IDLE);
    applyStimulus(3, 0, 1, 0, 5'd25, 0, 1, S_COOL);
    applyStimulus(1, 1, 1, 0, 5'd25, 0, 0, S_IDLE);
    applyStimulus(5, 0, 1, 0, 5'd25, 0, 0, S_IDLE);
    applyStimulus(1, 0, 1, 1, 5'd25, 0, 0, S_IDLE);
    applyStimulus(2, 0, 1, 0, 5'd25, 0, 1, S_COOL);
    while (plan.size() > 0) begin
      st = plan.pop_front();
      rst = st.r; enable = st.en; temp_valid = st.vld; temperature = st.t;
      tick();
      got = {heating, cooling, state};
      compared++;
      if (got !== st.exp) begin
        mismatched++;
        $display("[TB] FAIL reset_mid_run step %0d: got hcs=%b expected hcs=%b",
                 idx, got, st.exp);
      end
      idx++;
    end
  endtask

  initial begin
    $display("[TB] starting hvac_sequencer bench");
    test_reset();
    test_heat_cycle();
    test_cool_hysteresis();
    test_mode_change();
    test_enable_override();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
